// File: rtl/uart_rx_frame_controller_pkg.sv
// Shared definitions for the UART frame controllers:
// CRC16/CCITT constants and the receive FSM state encoding.
package uart_rx_frame_controller_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_frame_controller_crc.sv
// One-byte CRC16/CCITT fold, MSB-first, no reflection.
module crc16_byte_update
    import uart_rx_frame_controller_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] next_crc
);

    always_comb begin
        next_crc = crc;
        for (int i = 7; i >= 0; i--) begin
            if (next_crc[15] ^ data[i])
                next_crc = {next_crc[14:0], 1'b0} ^ CRC_POLY;
            else
                next_crc = {next_crc[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/uart_rx_frame_controller.sv
// Assembles payload + CRC16 bytes from the UART receiver into one block
// and offers it to the AES datapath with a valid/ack handshake.
module uart_rx_frame_controller
    import uart_rx_frame_controller_pkg::*;
#(
    parameter int          FRAME_BYTES = 16,
    parameter logic [15:0] CRC_INIT    = CRC_INIT_DEFAULT,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_err,
    input  logic                     frame_ack,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    output logic                     crc_err,
    output logic                     frame_abort,
    output logic                     overrun,
    output logic                     busy
);

    localparam int CNT_W = $clog2(FRAME_BYTES + 3);
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      crc;
    logic [15:0]      crc_next;
    logic             store;

    crc16_byte_update u_crc (
        .crc      (crc),
        .data     (rx_byte),
        .next_crc (crc_next)
    );

    // CRC bytes only feed the CRC; the block keeps payload bytes alone.
    assign store = byte_cnt < PAY_CNT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            crc         <= CRC_INIT;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            crc_err     <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_valid && !rx_err) begin
                        frame_data <= {frame_data[8*FRAME_BYTES-9:0], rx_byte};
                        crc        <= crc_next;
                        byte_cnt   <= CNT_W'(1);
                        gap_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (rx_valid && rx_err) begin
                        frame_abort <= 1'b1;
                        crc         <= CRC_INIT;
                        byte_cnt    <= '0;
                        gap_cnt     <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (rx_valid) begin
                        if (store)
                            frame_data <= {frame_data[8*FRAME_BYTES-9:0], rx_byte};
                        crc      <= crc_next;
                        byte_cnt <= byte_cnt + 1'b1;
                        gap_cnt  <= '0;
                        if (byte_cnt == LAST_CNT)
                            state <= CHECK;
                    end else if (gap_cnt == GAP_MAX) begin
                        frame_abort <= 1'b1;
                        crc         <= CRC_INIT;
                        byte_cnt    <= '0;
                        gap_cnt     <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // Counters reload here so HOLD can exit straight to IDLE.
                    crc      <= CRC_INIT;
                    byte_cnt <= '0;
                    gap_cnt  <= '0;
                    if (crc == 16'h0000) begin
                        frame_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        crc_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                HOLD: begin
                    overrun <= rx_valid;
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Directed bench with a frame-level reference model for the receive controller.
module tb_uart_rx_frame_controller;

    localparam int FB = 9;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_err = 1'b0;
    logic          frame_ack = 1'b0;
    logic [8*FB-1:0] frame_data;
    logic          frame_valid, crc_err, frame_abort, overrun, busy;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;
    int ov_seen = 0;

    uart_rx_frame_controller #(
        .FRAME_BYTES (FB),
        .CRC_INIT    (16'hFFFF),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_err      (rx_err),
        .frame_ack   (frame_ack),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .crc_err     (crc_err),
        .frame_abort (frame_abort),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8*FB-1:0] act,
                         input logic [8*FB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: whole byte xored into the top, then eight shifts.
    function automatic logic [15:0] fold(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Frame-level model: bytes collected, silence length, pending check, held block.
    bit          collecting, checking, holding;
    int          count, silent;
    logic [15:0] mcrc = 16'hFFFF;
    logic [8*FB-1:0] mdata = '0;
    bit          e_valid, e_crc_err, e_abort, e_overrun, e_busy;

    task automatic restart();
        collecting = 0;
        count = 0;
        silent = 0;
        mcrc = 16'hFFFF;
    endtask

    always @(posedge clk) begin
        e_crc_err = 0;
        e_abort = 0;
        e_overrun = 0;
        if (reset) begin
            restart();
            checking = 0;
            holding = 0;
            e_valid = 0;
            mdata = '0;
        end else if (holding) begin
            if (rx_valid) e_overrun = 1;
            if (frame_ack) begin
                holding = 0;
                e_valid = 0;
            end
        end else if (checking) begin
            checking = 0;
            if (mcrc == 16'h0000) begin
                holding = 1;
                e_valid = 1;
            end else begin
                e_crc_err = 1;
            end
            restart();
        end else if (rx_valid && rx_err) begin
            if (collecting) e_abort = 1;
            restart();
        end else if (rx_valid) begin
            if (count < FB) mdata = {mdata[8*FB-9:0], rx_byte};
            mcrc = fold(mcrc, rx_byte);
            count++;
            silent = 0;
            collecting = 1;
            if (count == FB + 2) begin
                collecting = 0;
                checking = 1;
            end
        end else if (collecting) begin
            silent++;
            if (silent == TO) begin
                e_abort = 1;
                restart();
            end
        end
        e_busy = collecting | checking | holding;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("frame_data", frame_data, mdata);
            check("frame_valid", 72'(frame_valid), 72'(e_valid));
            check("crc_err", 72'(crc_err), 72'(e_crc_err));
            check("frame_abort", 72'(frame_abort), 72'(e_abort));
            check("overrun", 72'(overrun), 72'(e_overrun));
            check("busy", 72'(busy), 72'(e_busy));
            if (overrun === 1'b1) ov_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_valid = 1'b1;
        rx_byte = b;
        rx_err = err;
        tick(1);
        rx_valid = 1'b0;
        rx_err = 1'b0;
    endtask

    logic [7:0] good [FB+2] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    localparam logic [8*FB-1:0] GOOD_DATA = 72'h313233343536373839;

    task automatic send_frame(input logic [7:0] last);
        for (int i = 0; i < FB + 1; i++) send(good[i], 1'b0);
        send(last, 1'b0);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        check("ack_valid_low", 72'(frame_valid), 72'(0));
        check("ack_busy_low", 72'(busy), 72'(0));
    endtask

    initial begin
        logic [15:0] c;
        int k, hit, ov0;
        c = 16'hFFFF;
        for (int i = 0; i < FB; i++) c = fold(c, good[i]);
        check("model_crc_check_value", 72'(c), 72'(16'h29B1));

        @(posedge clk);
        armed = 1'b1;
        tick(2);
        check("reset_valid", 72'(frame_valid), 72'(0));
        check("reset_data", frame_data, '0);
        check("reset_busy", 72'(busy), 72'(0));
        reset = 1'b0;
        tick(1);

        // good frame, latency, hold stability, ack
        send_frame(8'hB1);
        check("latency_cycle1", 72'(frame_valid), 72'(0));
        tick(1);
        check("latency_cycle2", 72'(frame_valid), 72'(1));
        check("good_data", frame_data, GOOD_DATA);
        tick(20);
        check("hold_valid", 72'(frame_valid), 72'(1));
        check("hold_data", frame_data, GOOD_DATA);
        ack();
        tick(2);

        // bad CRC, then a good frame
        send_frame(8'hB0);
        tick(1);
        check("bad_crc_pulse", 72'(crc_err), 72'(1));
        check("bad_crc_valid", 72'(frame_valid), 72'(0));
        tick(1);
        check("bad_crc_once", 72'(crc_err), 72'(0));
        check("bad_crc_busy", 72'(busy), 72'(0));
        send_frame(8'hB1);
        tick(1);
        check("after_bad_valid", 72'(frame_valid), 72'(1));
        ack();

        // timeout after 5 bytes
        for (int i = 0; i < 5; i++) send(good[i], 1'b0);
        hit = 0;
        for (k = 1; k <= TO + 10 && hit == 0; k++) begin
            tick(1);
            if (frame_abort === 1'b1) hit = k;
        end
        check("timeout_cycles", 72'(hit), 72'(TO));
        send_frame(8'hB1);
        tick(1);
        check("after_timeout_valid", 72'(frame_valid), 72'(1));
        ack();

        // rx_err on the 7th byte, then rx_err alone in IDLE
        for (int i = 0; i < 6; i++) send(good[i], 1'b0);
        send(good[6], 1'b1);
        check("rx_err_abort", 72'(frame_abort), 72'(1));
        check("rx_err_busy", 72'(busy), 72'(0));
        tick(1);
        send(8'h55, 1'b1);
        check("idle_err_busy", 72'(busy), 72'(0));
        check("idle_err_abort", 72'(frame_abort), 72'(0));
        tick(1);

        // overrun in HOLD, including a byte coinciding with ack
        send_frame(8'hB1);
        tick(2);
        ov0 = ov_seen;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        tick(1);
        frame_ack = 1'b1;
        send(8'hA3, 1'b0);
        frame_ack = 1'b0;
        tick(2);
        check("overrun_count", 72'(ov_seen - ov0), 72'(3));
        check("overrun_data", frame_data, GOOD_DATA);
        check("overrun_idle", 72'(busy), 72'(0));

        // reset in the middle of a frame
        for (int i = 0; i < 3; i++) send(good[i], 1'b0);
        reset = 1'b1;
        send(good[3], 1'b0);
        reset = 1'b0;
        check("midreset_data", frame_data, '0);
        check("midreset_busy", 72'(busy), 72'(0));
        check("midreset_valid", 72'(frame_valid), 72'(0));
        send_frame(8'hB1);
        tick(1);
        check("after_reset_valid", 72'(frame_valid), 72'(1));
        check("after_reset_data", frame_data, GOOD_DATA);
        ack();
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
